// File: rtl/mips_irq_ctl.sv
// Memory-mapped interrupt controller for the mips789 device bus: NCH synchronised sources,
// a fixed-priority grant held until acknowledged. Define IRQ_LEVEL_EN for per-channel level mode.
`ifndef DMEM_SW
`define DMEM_SW 4'd5
`endif
`ifndef DMEM_LW
`define DMEM_LW 4'd6
`endif

module mips_irq_ctl #(
    parameter int unsigned NCH       = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic [31:0]     din,
    input  logic [3:0]      mem_ctl,
    output logic [31:0]     dout,
    input  logic [NCH-1:0]  irq_src,
    input  logic            irq_ack_i,
    output logic            irq_req_o,
    output logic [31:0]     irq_addr_o,
    output logic [3:0]      irq_id_o
);

    typedef enum logic [0:0] {StIdle, StReq} state_t;
    state_t state_q;

    logic [NCH-1:0] s1_q, s2_q, s3_q;
    logic [NCH-1:0] pending_q, pending_d, enable_q;
    logic           ctrl_q;
    logic [31:0]    vector_q [NCH];
`ifdef IRQ_LEVEL_EN
    logic [NCH-1:0] mode_q;
`endif

    logic [31:0]    off;
    logic           in_win, wr, rd;
    logic           wr_ctrl, wr_enable, wr_pending;
`ifdef IRQ_LEVEL_EN
    logic           wr_mode;
`endif
    logic [NCH-1:0] wr_vec;
    logic [31:0]    rdata;

    logic [NCH-1:0] set_mask, w1c_mask, ack_mask, gsel, req_vec;
    logic           grant_any;
    logic [3:0]     grant_id;
    logic [31:0]    grant_vec;
    logic           withdraw;

    // Window is 128 bytes: control block at 0x00..0x10, vectors at 0x40..0x7C.
    assign off    = addr - BASE_ADDR;
    assign in_win = (off[31:7] == 25'd0) && (off[1:0] == 2'd0);
    assign wr     = in_win && (mem_ctl == `DMEM_SW);
    assign rd     = in_win && (mem_ctl == `DMEM_LW);

    assign wr_ctrl    = wr && !off[6] && (off[5:2] == 4'd0);
    assign wr_enable  = wr && !off[6] && (off[5:2] == 4'd1);
    assign wr_pending = wr && !off[6] && (off[5:2] == 4'd2);
`ifdef IRQ_LEVEL_EN
    assign wr_mode    = wr && !off[6] && (off[5:2] == 4'd3);
`endif

    always_comb begin
        wr_vec = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_vec[i] = wr && off[6] && (off[5:2] == 4'(i));
        end
    end

    always_comb begin
        rdata = '0;
        if (off[6]) begin
            for (int i = 0; i < NCH; i++) begin
                if (off[5:2] == 4'(i)) rdata = vector_q[i];
            end
        end else begin
            case (off[5:2])
                4'd0:    rdata = {31'd0, ctrl_q};
                4'd1:    rdata = 32'(enable_q);
                4'd2:    rdata = 32'(pending_q);
`ifdef IRQ_LEVEL_EN
                4'd3:    rdata = 32'(mode_q);
`endif
                4'd4:    rdata = {state_q == StReq, 27'd0, irq_id_o};
                default: rdata = '0;
            endcase
        end
    end

    // One-hot of the currently presented channel.
    always_comb begin
        gsel = '0;
        for (int i = 0; i < NCH; i++) begin
            gsel[i] = (irq_id_o == 4'(i));
        end
    end

    always_comb begin
        set_mask = s2_q & ~s3_q;
`ifdef IRQ_LEVEL_EN
        set_mask = set_mask | (s2_q & mode_q);
`endif
        w1c_mask  = wr_pending ? din[NCH-1:0] : '0;
        ack_mask  = (state_q == StReq && irq_ack_i) ? gsel : '0;
        // Set wins over both clear sources.
        pending_d = (pending_q & ~w1c_mask & ~ack_mask) | set_mask;
    end

    // Descending scan so the lowest pending index is the one left standing.
    always_comb begin
        req_vec   = pending_q & enable_q;
        grant_any = |req_vec;
        grant_id  = '0;
        grant_vec = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                grant_id  = 4'(i);
                grant_vec = vector_q[i];
            end
        end
    end

    assign withdraw = !ctrl_q || !(|(enable_q & gsel)) || !(|(pending_q & gsel));

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            ctrl_q    <= 1'b0;
            dout      <= '0;
`ifdef IRQ_LEVEL_EN
            mode_q    <= '0;
`endif
            for (int i = 0; i < NCH; i++) begin
                vector_q[i] <= '0;
            end
        end else begin
            s1_q      <= irq_src;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            if (wr_ctrl)   ctrl_q   <= din[0];
            if (wr_enable) enable_q <= din[NCH-1:0];
`ifdef IRQ_LEVEL_EN
            if (wr_mode)   mode_q   <= din[NCH-1:0];
`endif
            for (int i = 0; i < NCH; i++) begin
                if (wr_vec[i]) vector_q[i] <= din;
            end
            dout <= rd ? rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            irq_req_o  <= 1'b0;
            irq_addr_o <= '0;
            irq_id_o   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ctrl_q && grant_any) begin
                        irq_id_o   <= grant_id;
                        irq_addr_o <= grant_vec;
                        irq_req_o  <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (irq_ack_i || withdraw) begin
                        irq_req_o <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    irq_req_o <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Directed self-checking bench for mips_irq_ctl with hand-computed expectations.
`ifndef DMEM_SW
`define DMEM_SW 4'd5
`endif
`ifndef DMEM_LW
`define DMEM_LW 4'd6
`endif

module tb_mips_irq_ctl;

    localparam int unsigned NCH    = 4;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_EN   = BASE + 32'h04;
    localparam logic [31:0] A_PEND = BASE + 32'h08;
    localparam logic [31:0] A_MODE = BASE + 32'h0C;
    localparam logic [31:0] A_ACT  = BASE + 32'h10;
    localparam logic [31:0] A_VEC  = BASE + 32'h40;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    addr;
    logic [31:0]    din;
    logic [3:0]     mem_ctl;
    logic [31:0]    dout;
    logic [NCH-1:0] irq_src;
    logic           irq_ack;
    logic           irq_req;
    logic [31:0]    irq_addr;
    logic [3:0]     irq_id;

    int n_cmp  = 0;
    int n_fail = 0;

    mips_irq_ctl #(.NCH(NCH), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .din        (din),
        .mem_ctl    (mem_ctl),
        .dout       (dout),
        .irq_src    (irq_src),
        .irq_ack_i  (irq_ack),
        .irq_req_o  (irq_req),
        .irq_addr_o (irq_addr),
        .irq_id_o   (irq_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        din     = d;
        mem_ctl = `DMEM_SW;
        tick(1);
        mem_ctl = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr    = a;
        mem_ctl = `DMEM_LW;
        tick(1);
        mem_ctl = 4'd0;
        d       = dout;
    endtask

    task automatic pulse_src(input logic [NCH-1:0] m);
        irq_src = m;
        tick(1);
        irq_src = '0;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] regs [6];
        regs[0] = A_CTRL; regs[1] = A_EN; regs[2] = A_PEND;
        regs[3] = A_MODE; regs[4] = A_ACT; regs[5] = A_VEC;
        do_reset();
        n_cmp++;
        if (irq_req !== 1'b0 || irq_addr !== 32'h0 || irq_id !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%h id=%h, want 0/0/0", irq_req, irq_addr, irq_id);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(regs[i], rd);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: dout=%h, want 0", i, rd);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        bus_write(A_VEC + 32'h8, 32'h0000_0400);
        bus_write(A_EN, 32'h4);
        bus_write(A_CTRL, 32'h1);
        pulse_src(4'b0100);
        tick(2);
        n_cmp++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: req=%b at k+2, want 0", irq_req);
        end
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h4) begin
            n_fail++;
            $display("FAIL basic_pending: dout=%h, want 00000004", rd);
        end
        n_cmp++;
        if (irq_req !== 1'b1 || irq_addr !== 32'h400 || irq_id !== 4'd2) begin
            n_fail++;
            $display("FAIL basic_req: req=%b addr=%h id=%0d, want 1/400/2", irq_req, irq_addr, irq_id);
        end
        bus_read(A_ACT, rd);
        n_cmp++;
        if (rd !== 32'h8000_0002) begin
            n_fail++;
            $display("FAIL basic_active: dout=%h, want 80000002", rd);
        end
        tick(1);
        n_cmp++;
        if (dout !== 32'h0) begin
            n_fail++;
            $display("FAIL dout_idle: dout=%h, want 0", dout);
        end
        ack_pulse();
        n_cmp++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_ack: req=%b, want 0", irq_req);
        end
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_pend_clr: dout=%h, want 0", rd);
        end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        bus_write(A_VEC + 32'h4, 32'h0000_1100);
        bus_write(A_VEC + 32'hC, 32'h0000_3300);
        bus_write(A_EN, 32'hF);
        pulse_src(4'b1010);
        tick(3);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd1 || irq_addr !== 32'h1100) begin
            n_fail++;
            $display("FAIL prio_first: req=%b id=%0d addr=%h, want 1/1/1100", irq_req, irq_id, irq_addr);
        end
        ack_pulse();
        n_cmp++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_gap: req=%b, want 0", irq_req);
        end
        tick(1);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd3 || irq_addr !== 32'h3300) begin
            n_fail++;
            $display("FAIL prio_second: req=%b id=%0d addr=%h, want 1/3/3300", irq_req, irq_id, irq_addr);
        end
        ack_pulse();
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h0 || irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_done: pend=%h req=%b, want 0/0", rd, irq_req);
        end
    endtask

    task automatic test_ctrl_withdraw();
        logic [31:0] rd;
        pulse_src(4'b0001);
        tick(3);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd0) begin
            n_fail++;
            $display("FAIL wd_raise: req=%b id=%0d, want 1/0", irq_req, irq_id);
        end
        bus_write(A_CTRL, 32'h0);
        n_cmp++;
        if (irq_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_hold: req=%b on write edge, want 1", irq_req);
        end
        tick(1);
        n_cmp++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_drop: req=%b, want 0", irq_req);
        end
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL wd_pend_kept: dout=%h, want 00000001", rd);
        end
        bus_write(A_CTRL, 32'h1);
        tick(1);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd0) begin
            n_fail++;
            $display("FAIL wd_reraise: req=%b id=%0d, want 1/0", irq_req, irq_id);
        end
        ack_pulse();
    endtask

    task automatic test_w1c_withdraw();
        logic [31:0] rd;
        pulse_src(4'b0010);
        tick(3);
        bus_write(A_PEND, 32'h2);
        tick(1);
        n_cmp++;
        if (irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_withdraw: req=%b, want 0", irq_req);
        end
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear: dout=%h, want 0", rd);
        end
    endtask

    task automatic test_set_beats_clear();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'h0);
        pulse_src(4'b0001);
        tick(1);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL set_beats_w1c: dout=%h, want 00000001", rd);
        end
        ack_pulse();
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h1 || irq_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle_ignored: pend=%h req=%b, want 1/0", rd, irq_req);
        end
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_plain: dout=%h, want 0", rd);
        end
    endtask

    task automatic test_map_edges();
        logic [31:0] rd;
        bus_write(A_VEC + 32'h14, 32'hDEAD_BEEF);
        bus_read(A_VEC + 32'h14, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL vec_oob: dout=%h, want 0", rd);
        end
        bus_write(A_CTRL, 32'hFFFF_FFFF);
        bus_read(A_CTRL, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL ctrl_bits: dout=%h, want 00000001", rd);
        end
        bus_write(A_CTRL, 32'h0);
        bus_read(A_VEC + 32'h8, rd);
        n_cmp++;
        if (rd !== 32'h400) begin
            n_fail++;
            $display("FAIL vec2_read: dout=%h, want 00000400", rd);
        end
`ifndef IRQ_LEVEL_EN
        bus_write(A_MODE, 32'hF);
        bus_read(A_MODE, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL mode_ro: dout=%h, want 0", rd);
        end
`endif
        bus_write(A_CTRL, 32'h1);
    endtask

`ifdef IRQ_LEVEL_EN
    task automatic test_level();
        logic [31:0] rd;
        bus_write(A_MODE, 32'h1);
        irq_src = 4'b0001;
        tick(4);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd0) begin
            n_fail++;
            $display("FAIL lvl_raise: req=%b id=%0d, want 1/0", irq_req, irq_id);
        end
        ack_pulse();
        tick(1);
        n_cmp++;
        if (irq_req !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl_reraise: req=%b, want 1", irq_req);
        end
        irq_src = '0;
        tick(3);
        ack_pulse();
        tick(2);
        bus_read(A_PEND, rd);
        n_cmp++;
        if (irq_req !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL lvl_quiet: req=%b pend=%h, want 0/0", irq_req, rd);
        end
        bus_write(A_MODE, 32'h0);
    endtask
`endif

    task automatic test_mid_reset();
        pulse_src(4'b0100);
        tick(3);
        n_cmp++;
        if (irq_req !== 1'b1 || irq_id !== 4'd2) begin
            n_fail++;
            $display("FAIL mr_raise: req=%b id=%0d, want 1/2", irq_req, irq_id);
        end
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        n_cmp++;
        if (irq_req !== 1'b0 || irq_addr !== 32'h0 || irq_id !== 4'h0) begin
            n_fail++;
            $display("FAIL mr_drop: req=%b addr=%h id=%h, want 0/0/0", irq_req, irq_addr, irq_id);
        end
    endtask

    initial begin
        rst     = 1'b0;
        addr    = '0;
        din     = '0;
        mem_ctl = 4'd0;
        irq_src = '0;
        irq_ack = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_ctrl_withdraw();
        test_w1c_withdraw();
        test_set_beats_clear();
        test_map_edges();
`ifdef IRQ_LEVEL_EN
        test_level();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
